// File: rtl/egress_pkt_fifo.sv
// egress_pkt_fifo: per-port store-and-forward egress buffer.
// Buffers sop/eop framed byte-stream packets whole and presents only committed
// packets to the Tx driver (first-word fall-through, valid/ready).
// Overflowing, aborted or over-long packets are dropped and counted.
// Build macro EGRESS_PKT_STATS_EN adds the tx_pkt_cnt and max_occ statistics ports.
module egress_pkt_fifo #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   pkt_cnt,
    output logic [15:0]       drop_cnt,
    output logic              empty
`ifdef EGRESS_PKT_STATS_EN
    ,
    output logic [31:0]       tx_pkt_cnt,
    output logic [ADDR_W:0]   max_occ
`endif
);

    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned WORD_W = DATA_W + 2;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_e;

    // Storage word layout: {sop, eop, data}
    logic [WORD_W-1:0] mem_q [DEPTH];

    state_e            state_q,     state_d;
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]  cm_ptr_q,    cm_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [PTR_W-1:0]  pkt_cnt_q,   pkt_cnt_d;
    logic [15:0]       drop_cnt_q,  drop_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              empty_q,     empty_d;
    logic [WORD_W-1:0] out_word_q,  out_word_d;

    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_word;
    logic              commit;
    logic              drop_abort;
    logic              drop_full;
    logic [PTR_W-1:0]  occ_wr;
    logic [PTR_W-1:0]  occ_cm;
    logic              space_wr;
    logic              space_cm;
    logic              rd_fire;
    logic              eop_fire;
    logic [1:0]        drop_add;
    logic [16:0]       drop_sum;

    // Free space from registered pointers only; a same-cycle read does not help
    always_comb begin
        occ_wr   = wr_ptr_q - rd_ptr_q;
        occ_cm   = cm_ptr_q - rd_ptr_q;
        space_wr = (occ_wr < DEPTH_P);
        space_cm = (occ_cm < DEPTH_P);
        wr_word  = {in_sop, in_eop, in_data};
    end

    // Write-side packet FSM: tentative write, commit on eop, rewind on drop
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        we         = 1'b0;
        wr_addr    = wr_ptr_q[ADDR_W-1:0];
        commit     = 1'b0;
        drop_abort = 1'b0;
        drop_full  = 1'b0;
        if (in_valid) begin
            if (in_sop) begin
                // Every sop restarts at the commit boundary; an open packet is abandoned
                drop_abort = (state_q == RECV);
                if (space_cm) begin
                    we       = 1'b1;
                    wr_addr  = cm_ptr_q[ADDR_W-1:0];
                    wr_ptr_d = cm_ptr_q + PTR_W'(1);
                    if (in_eop) begin
                        cm_ptr_d = cm_ptr_q + PTR_W'(1);
                        commit   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = RECV;
                    end
                end else begin
                    drop_full = 1'b1;
                    wr_ptr_d  = cm_ptr_q;
                    state_d   = in_eop ? IDLE : DROP;
                end
            end else begin
                case (state_q)
                    RECV: begin
                        if (space_wr) begin
                            we       = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                            if (in_eop) begin
                                cm_ptr_d = wr_ptr_q + PTR_W'(1);
                                commit   = 1'b1;
                                state_d  = IDLE;
                            end
                        end else begin
                            drop_full = 1'b1;
                            wr_ptr_d  = cm_ptr_q;
                            state_d   = in_eop ? IDLE : DROP;
                        end
                    end
                    DROP: begin
                        if (in_eop) begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        // Orphan beat outside a packet: silently discarded
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // Read side, packet and drop counters, registered output view
    always_comb begin
        rd_fire  = out_valid_q & out_ready;
        eop_fire = rd_fire & out_word_q[WORD_W-2];
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_fire);

        pkt_cnt_d = pkt_cnt_q;
        case ({commit, eop_fire})
            2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_W'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_W'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase

        drop_add   = 2'(drop_abort) + 2'(drop_full);
        drop_sum   = 17'(drop_cnt_q) + 17'(drop_add);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

        out_valid_d = (rd_ptr_d != cm_ptr_d);
        empty_d     = (rd_ptr_d == cm_ptr_d);
        // Forward a beat being written to the slot the read pointer lands on
        if (we && (wr_addr == rd_ptr_d[ADDR_W-1:0])) begin
            out_word_d = wr_word;
        end else begin
            out_word_d = mem_q[rd_ptr_d[ADDR_W-1:0]];
        end
    end

    // State, pointer and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cm_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            empty_q     <= 1'b1;
            out_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cm_ptr_q    <= cm_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            out_valid_q <= out_valid_d;
            empty_q     <= empty_d;
            out_word_q  <= out_word_d;
        end
    end

    // Packet storage array
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sop   = out_word_q[WORD_W-1];
    assign out_eop   = out_word_q[WORD_W-2];
    assign out_data  = out_word_q[DATA_W-1:0];
    assign pkt_cnt   = pkt_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign empty     = empty_q;

`ifdef EGRESS_PKT_STATS_EN
    logic [31:0]      tx_pkt_cnt_q, tx_pkt_cnt_d;
    logic [PTR_W-1:0] max_occ_q,    max_occ_d;
    logic [PTR_W-1:0] occ_commit_d;

    // Transmitted-packet count and committed-occupancy high-water mark
    always_comb begin
        tx_pkt_cnt_d = tx_pkt_cnt_q + 32'(eop_fire);
        occ_commit_d = cm_ptr_d - rd_ptr_d;
        max_occ_d    = (occ_commit_d > max_occ_q) ? occ_commit_d : max_occ_q;
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_pkt_cnt_q <= '0;
            max_occ_q    <= '0;
        end else begin
            tx_pkt_cnt_q <= tx_pkt_cnt_d;
            max_occ_q    <= max_occ_d;
        end
    end

    assign tx_pkt_cnt = tx_pkt_cnt_q;
    assign max_occ    = max_occ_q;
`endif

endmodule

// File: doc/egress_pkt_fifo.md
Name: egress_pkt_fifo

Overview:
- Per-port store-and-forward egress buffer, one instance per Tx port, directly downstream of simple_switch.
- Accepts byte-stream packets (sop/eop framed) from the switch and buffers them whole.
- Only fully received packets are presented to the Tx port driver, under a valid/ready handshake.
- Drops packets that overflow the buffer, are aborted, or exceed DEPTH; counts every drop.

Parameters:
DATA_W, 8, payload beat width in bits
DEPTH, 16, buffer entries; power of two, >=4; ADDR_W = $clog2(DEPTH)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  beat present from switch (no backpressure; beat consumed or discarded every cycle)
in_sop  input  1  first beat of packet
in_eop  input  1  last beat of packet
in_data  input  DATA_W  beat payload
out_valid  output  1  committed beat available
out_ready  input  1  Tx driver accepts beat
out_sop  output  1  first beat of output packet
out_eop  output  1  last beat of output packet
out_data  output  DATA_W  output payload
pkt_cnt  output  ADDR_W+1  committed packets currently buffered
drop_cnt  output  16  dropped-packet count, saturating at 16'hFFFF
empty  output  1  rd_ptr == cm_ptr

Behaviour:
- Reset (async assert): wr_ptr, cm_ptr, rd_ptr = 0; state = IDLE; pkt_cnt = 0; drop_cnt = 0; out_valid = 0; empty = 1. Release is synchronous to clk.
- Storage: DEPTH x (DATA_W+2); sop and eop are stored with each beat.
- Pointers are ADDR_W+1 bits with wrap via MSB. Three pointers:
  - wr_ptr: tentative write position
  - cm_ptr: commit boundary
  - rd_ptr: read position
- free = DEPTH - (wr_ptr - rd_ptr), computed from registered pointers at cycle start. A same-cycle read does not raise free until the next cycle.
- Write FSM states: IDLE, RECV, DROP.
  - IDLE, in_valid & in_sop, free>0: write beat.
    - If in_eop: cm_ptr <= wr_ptr+1 (commit), stay IDLE.
    - Else: go RECV.
  - IDLE, in_valid & in_sop, free==0: drop_cnt++.
    - Go DROP, or stay IDLE if in_eop.
  - IDLE, in_valid & !in_sop (orphan beat): discard, not counted.
  - RECV, in_valid & !in_sop, free>0: write beat.
    - If in_eop: commit, go IDLE.
  - RECV, in_valid & !in_sop, free==0 (overflow): wr_ptr <= cm_ptr (rewind), drop_cnt++.
    - Go DROP, or IDLE if in_eop.
  - RECV, in_valid & in_sop (abort): rewind wr_ptr to cm_ptr, drop_cnt++. The new beat is written at cm_ptr as a fresh packet start, with IDLE rules applied to it, using free recomputed against cm_ptr.
  - DROP: discard beats until in_eop, then go IDLE.
    - in_sop in DROP starts a new packet per IDLE rules; no extra drop count.
- A packet longer than DEPTH beats is always dropped.
- Output is first-word fall-through:
  - out_valid = (rd_ptr != cm_ptr); out_data/out_sop/out_eop = mem[rd_ptr].
  - rd_ptr++ on out_valid & out_ready.
  - Data and flags hold stable while out_valid & !out_ready.
- Latency: the committing eop beat is accepted at edge N; its packet's first beat has out_valid=1 after edge N, i.e. 1 cycle.
- Uncommitted beats are never visible at the output.
- pkt_cnt: +1 on commit, -1 on out_eop handshake; both in the same cycle leaves it unchanged.
- Simultaneous write and read in one cycle are independent. Writing over entries freed that same cycle is prohibited by the free rule.
- rst asserted mid-packet: buffer contents discarded, no drop counted.

Optional Feature:
- Macro EGRESS_PKT_STATS_EN.
- Defined:
  - Adds output port tx_pkt_cnt [31:0]: +1 per out_eop handshake, wraps at 2^32, reset 0.
  - Adds output port max_occ [ADDR_W:0]: high-water mark of (cm_ptr - rd_ptr), reset 0.
- Undefined: both ports and their logic are absent; all other behaviour identical.

Test Plan:
- Single 4-beat packet 0x11,0x22,0x33,0x44 with out_ready=1 -> out_valid rises 1 cycle after the eop beat; outputs 0x11..0x44 with sop on the first beat, eop on the last; pkt_cnt 0->1->0; drop_cnt=0.
- out_ready=0, send 5-beat then 3-beat packet -> pkt_cnt=2, empty=0, out_data held at the first beat. Assert out_ready -> 8 beats in order.
- DEPTH=16, out_ready=0, send 20-beat packet -> drop_cnt=1, pkt_cnt=0, empty=1. A following 2-beat packet is buffered and output intact.
- 3-beat packet interrupted by a new sop after beat 2 -> drop_cnt=1; only the second packet is output; orphan beats sent in IDLE produce no output and no count.
- Buffer holding 14 committed beats, 4-beat packet arrives while draining at 1 beat/cycle -> drop if free hits 0 before eop, else accept. The bench checks the free-at-cycle-start rule cycle by cycle.
- Assert rst mid-packet with 2 packets buffered -> all outputs at reset values immediately (async); subsequent traffic operates normally. With EGRESS_PKT_STATS_EN, tx_pkt_cnt and max_occ = 0.
